// File: rtl/cache_tag_ctrl.sv
// Tag and state controller for a set-associative cache with true-LRU replacement,
// selectable write-back/write-through policy and saturating statistics counters.
module cache_tag_ctrl #(
    parameter int SETS         = 256,
    parameter int ASSOC        = 4,
    parameter int LINESIZE     = 32,
    parameter int ADDRESS_SIZE = 32,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_rw,
    input  logic [ADDRESS_SIZE-1:0] req_addr,
    input  logic                    wpolicy,
    output logic                    resp_valid,
    output logic                    resp_hit,
    output logic                    mem_req_valid,
    output logic                    mem_req_we,
    output logic [ADDRESS_SIZE-1:0] mem_req_addr,
    input  logic                    mem_ack,
    output logic [CNT_WIDTH-1:0]    cnt_access,
    output logic [CNT_WIDTH-1:0]    cnt_read,
    output logic [CNT_WIDTH-1:0]    cnt_write,
    output logic [CNT_WIDTH-1:0]    cnt_hit,
    output logic [CNT_WIDTH-1:0]    cnt_miss,
    output logic [CNT_WIDTH-1:0]    cnt_evict,
    output logic [CNT_WIDTH-1:0]    cnt_wb
);
    localparam int OFF_W  = $clog2(LINESIZE);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDRESS_SIZE - IDX_W - OFF_W;
    localparam int AGE_W  = (ASSOC > 1) ? $clog2(ASSOC) : 1;
    localparam int WAY_W  = AGE_W;
    localparam int LINE_W = ADDRESS_SIZE - OFF_W;

    localparam int C_ACCESS = 0;
    localparam int C_READ   = 1;
    localparam int C_WRITE  = 2;
    localparam int C_HIT    = 3;
    localparam int C_MISS   = 4;
    localparam int C_EVICT  = 5;
    localparam int C_WB     = 6;
    localparam int NCNT     = 7;

    if (SETS < 2 || SETS > (1 << 20) || (SETS & (SETS - 1)) != 0) begin : g_bad_sets
        $fatal(1, "cache_tag_ctrl: SETS must be a power of 2 in 2..2**20");
    end
    if (ASSOC < 1 || ASSOC > 8 || (ASSOC & (ASSOC - 1)) != 0) begin : g_bad_assoc
        $fatal(1, "cache_tag_ctrl: ASSOC must be a power of 2 in 1..8");
    end
    if (LINESIZE < 4 || LINESIZE > 128 || (LINESIZE & (LINESIZE - 1)) != 0) begin : g_bad_line
        $fatal(1, "cache_tag_ctrl: LINESIZE must be a power of 2 in 4..128");
    end
    if (ADDRESS_SIZE <= IDX_W + OFF_W || CNT_WIDTH < 1) begin : g_bad_width
        $fatal(1, "cache_tag_ctrl: ADDRESS_SIZE too small or CNT_WIDTH < 1");
    end

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, WT, RESP} state_t;
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [AGE_W-1:0] age_t;
    typedef logic [WAY_W-1:0] way_t;
    typedef logic [IDX_W-1:0] idx_t;

    state_t               state_q, state_d;
    logic                 rw_q, rw_d;
    logic                 wpol_q, wpol_d;
    logic                 hit_q, hit_d;
    logic [LINE_W-1:0]    line_q, line_d;
    way_t                 victim_q, victim_d;
    tag_t                 tag_q   [SETS][ASSOC];
    tag_t                 tag_d   [SETS][ASSOC];
    logic                 valid_q [SETS][ASSOC];
    logic                 valid_d [SETS][ASSOC];
    logic                 dirty_q [SETS][ASSOC];
    logic                 dirty_d [SETS][ASSOC];
    age_t                 age_q   [SETS][ASSOC];
    age_t                 age_d   [SETS][ASSOC];
    logic [CNT_WIDTH-1:0] cnt_q   [NCNT];
    logic [CNT_WIDTH-1:0] cnt_d   [NCNT];

    idx_t idx;
    tag_t req_tag;
    logic hit_any;
    way_t hit_way;
    way_t victim_way;
    logic touch;
    way_t touch_way;
    logic unused_offset;

    assign unused_offset = ^req_addr[OFF_W-1:0];

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Victim order: lowest invalid way wins, else the oldest (age ASSOC-1) way.
    always_comb begin
        idx        = line_q[IDX_W-1:0];
        req_tag    = line_q[LINE_W-1:IDX_W];
        hit_any    = 1'b0;
        hit_way    = '0;
        victim_way = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == req_tag) begin
                hit_any = 1'b1;
                hit_way = way_t'(w);
            end
        end
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (age_q[idx][w] == age_t'(ASSOC - 1)) begin
                victim_way = way_t'(w);
            end
        end
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                victim_way = way_t'(w);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        wpol_d    = wpol_q;
        hit_d     = hit_q;
        line_d    = line_q;
        victim_d  = victim_q;
        tag_d     = tag_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        age_d     = age_q;
        cnt_d     = cnt_q;
        touch     = 1'b0;
        touch_way = '0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    rw_d    = req_rw;
                    wpol_d  = wpolicy;
                    line_d  = req_addr[ADDRESS_SIZE-1:OFF_W];
                    state_d = LOOKUP;
                    cnt_d[C_ACCESS] = sat_inc(cnt_q[C_ACCESS]);
                    if (req_rw) cnt_d[C_WRITE] = sat_inc(cnt_q[C_WRITE]);
                    else        cnt_d[C_READ]  = sat_inc(cnt_q[C_READ]);
                end
            end
            LOOKUP: begin
                hit_d = hit_any;
                if (hit_any) begin
                    cnt_d[C_HIT] = sat_inc(cnt_q[C_HIT]);
                    touch        = 1'b1;
                    touch_way    = hit_way;
                    if (rw_q && wpol_q) begin
                        state_d = WT;
                    end else begin
                        if (rw_q) dirty_d[idx][hit_way] = 1'b1;
                        state_d = RESP;
                    end
                end else begin
                    cnt_d[C_MISS] = sat_inc(cnt_q[C_MISS]);
                    victim_d      = victim_way;
                    // Write-through misses go straight to memory without touching tags or ages.
                    if (rw_q && wpol_q) begin
                        state_d = WT;
                    end else begin
                        if (valid_q[idx][victim_way]) cnt_d[C_EVICT] = sat_inc(cnt_q[C_EVICT]);
                        state_d = (valid_q[idx][victim_way] && dirty_q[idx][victim_way]) ? WB : FILL;
                    end
                end
            end
            WB: begin
                if (mem_ack) begin
                    cnt_d[C_WB] = sat_inc(cnt_q[C_WB]);
                    state_d     = FILL;
                end
            end
            FILL: begin
                if (mem_ack) begin
                    tag_d[idx][victim_q]   = req_tag;
                    valid_d[idx][victim_q] = 1'b1;
                    dirty_d[idx][victim_q] = rw_q & ~wpol_q;
                    touch                  = 1'b1;
                    touch_way              = victim_q;
                    state_d                = RESP;
                end
            end
            WT: begin
                if (mem_ack) state_d = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // True LRU: ages younger than the touched way's old age shift up by one.
        if (touch) begin
            for (int w = 0; w < ASSOC; w++) begin
                if (way_t'(w) == touch_way) begin
                    age_d[idx][w] = '0;
                end else if (age_q[idx][w] < age_q[idx][touch_way]) begin
                    age_d[idx][w] = age_q[idx][w] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            rw_q     <= 1'b0;
            wpol_q   <= 1'b0;
            hit_q    <= 1'b0;
            line_q   <= '0;
            victim_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < ASSOC; w++) begin
                    tag_q[s][w]   <= '0;
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= age_t'(w);
                end
            end
            for (int c = 0; c < NCNT; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rw_q     <= rw_d;
            wpol_q   <= wpol_d;
            hit_q    <= hit_d;
            line_q   <= line_d;
            victim_q <= victim_d;
            tag_q    <= tag_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            age_q    <= age_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req_ready     = reset && (state_q == IDLE);
    assign mem_req_valid = reset && (state_q == WB || state_q == FILL || state_q == WT);
    assign mem_req_we    = mem_req_valid && (state_q != FILL);
    assign resp_valid    = reset && (state_q == RESP);
    assign resp_hit      = resp_valid && hit_q;

    always_comb begin
        mem_req_addr = '0;
        if (mem_req_valid) begin
            if (state_q == WB) mem_req_addr = {tag_q[idx][victim_q], idx, {OFF_W{1'b0}}};
            else               mem_req_addr = {req_tag, idx, {OFF_W{1'b0}}};
        end
    end

    assign cnt_access = cnt_q[C_ACCESS];
    assign cnt_read   = cnt_q[C_READ];
    assign cnt_write  = cnt_q[C_WRITE];
    assign cnt_hit    = cnt_q[C_HIT];
    assign cnt_miss   = cnt_q[C_MISS];
    assign cnt_evict  = cnt_q[C_EVICT];
    assign cnt_wb     = cnt_q[C_WB];

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Directed bench for cache_tag_ctrl: 4 sets, 2 ways, 32-byte lines, 16-bit addresses,
// 4-bit counters so that saturation is reached within the vector table.
module tb_cache_tag_ctrl;
    localparam int AW = 16;
    localparam int CW = 4;
    localparam int NV = 17;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_rw;
    logic [AW-1:0] req_addr;
    logic          wpolicy;
    logic          resp_valid;
    logic          resp_hit;
    logic          mem_req_valid;
    logic          mem_req_we;
    logic [AW-1:0] mem_req_addr;
    logic          mem_ack;
    logic [CW-1:0] cnt_access, cnt_read, cnt_write, cnt_hit, cnt_miss, cnt_evict, cnt_wb;

    always #5 clk = ~clk;

    cache_tag_ctrl #(
        .SETS(4), .ASSOC(2), .LINESIZE(32), .ADDRESS_SIZE(AW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .wpolicy(wpolicy),
        .resp_valid(resp_valid), .resp_hit(resp_hit),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_ack(mem_ack),
        .cnt_access(cnt_access), .cnt_read(cnt_read), .cnt_write(cnt_write),
        .cnt_hit(cnt_hit), .cnt_miss(cnt_miss), .cnt_evict(cnt_evict), .cnt_wb(cnt_wb)
    );

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic        pol;
        logic        hit;
        int          nmem;
        logic [16:0] m0;
        logic [16:0] m1;
        int          lat;
        int          hits;
        int          misses;
        int          evicts;
        int          wbs;
    } vec_t;

    vec_t vecs [NV];

    int total = 0;
    int bad = 0;
    int m_access = 0;
    int m_read = 0;
    int m_write = 0;

    logic        got_hit;
    int          n_mem;
    logic [16:0] m0, m1;
    int          lat;
    logic        unstable;
    int          extra;

    function automatic vec_t mk(logic rw, logic [15:0] a, logic p, logic h, int n,
                                logic [16:0] x0, logic [16:0] x1, int l,
                                int hh, int mm, int ee, int bb);
        vec_t v;
        v.rw = rw; v.addr = a; v.pol = p; v.hit = h; v.nmem = n; v.m0 = x0; v.m1 = x1;
        v.lat = l; v.hits = hh; v.misses = mm; v.evicts = ee; v.wbs = bb;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Issues one request and plays memory: acks each memory request after ack_delay
    // idle cycles, logging {we, addr} of each new request and watching for stability.
    task automatic applyStimulus(input logic rw, input logic [15:0] addr, input logic pol,
                                 input int ack_delay, output logic o_hit, output int o_nmem,
                                 output logic [16:0] o_m0, output logic [16:0] o_m1,
                                 output int o_lat, output logic o_unstable);
        int guard;
        int wait_cnt;
        logic done;
        logic [16:0] cur;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            total++; bad++;
            $display("[TB] FAIL ready_timeout: req_ready got 0, want 1");
        end
        req_valid = 1'b1; req_rw = rw; req_addr = addr; wpolicy = pol;
        if (m_access < 15) m_access++;
        if (rw) begin if (m_write < 15) m_write++; end
        else    begin if (m_read < 15) m_read++; end
        @(negedge clk);
        req_valid = 1'b0;
        o_hit = 1'b0; o_nmem = 0; o_m0 = '0; o_m1 = '0; o_lat = 1; o_unstable = 1'b0;
        wait_cnt = 0; done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            if (resp_valid) begin
                o_hit = resp_hit;
                done = 1'b1;
            end else begin
                if (mem_req_valid) begin
                    cur = {mem_req_we, mem_req_addr};
                    if (wait_cnt == 0) begin
                        if (o_nmem == 0) o_m0 = cur;
                        else if (o_nmem == 1) o_m1 = cur;
                        o_nmem++;
                    end else if (cur != ((o_nmem == 1) ? o_m0 : o_m1)) begin
                        o_unstable = 1'b1;
                    end
                    if (req_ready) o_unstable = 1'b1;
                    mem_ack = (wait_cnt >= ack_delay);
                    wait_cnt = mem_ack ? 0 : wait_cnt + 1;
                end else begin
                    mem_ack = 1'b0;
                end
                @(negedge clk);
                o_lat++;
            end
        end
        mem_ack = 1'b0;
        if (!done) begin
            total++; bad++;
            $display("[TB] FAIL resp_timeout: resp_valid got 0, want 1");
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; wpolicy = 1'b0; mem_ack = 1'b0;

        // rw, addr, pol, hit, nmem, m0, m1, lat, hits, misses, evicts, wbs
        vecs[0]  = mk(0, 16'h0000, 0, 0, 1, 17'h00000, 17'h00000, 3, 0, 1, 0, 0);
        vecs[1]  = mk(0, 16'h0000, 0, 1, 0, 17'h00000, 17'h00000, 2, 1, 1, 0, 0);
        vecs[2]  = mk(1, 16'h0000, 0, 1, 0, 17'h00000, 17'h00000, 2, 2, 1, 0, 0);
        vecs[3]  = mk(0, 16'h0080, 0, 0, 1, 17'h00080, 17'h00000, 3, 2, 2, 0, 0);
        vecs[4]  = mk(0, 16'h0000, 0, 1, 0, 17'h00000, 17'h00000, 2, 3, 2, 0, 0);
        vecs[5]  = mk(0, 16'h0100, 0, 0, 1, 17'h00100, 17'h00000, 3, 3, 3, 1, 0);
        vecs[6]  = mk(0, 16'h0080, 0, 0, 2, 17'h10000, 17'h00080, 4, 3, 4, 2, 1);
        vecs[7]  = mk(1, 16'h0040, 1, 0, 1, 17'h10040, 17'h00000, 3, 3, 5, 2, 1);
        vecs[8]  = mk(0, 16'h0040, 0, 0, 1, 17'h00040, 17'h00000, 3, 3, 6, 2, 1);
        vecs[9]  = mk(1, 16'h0040, 1, 1, 1, 17'h10040, 17'h00000, 3, 4, 6, 2, 1);
        vecs[10] = mk(1, 16'h0080, 0, 1, 0, 17'h00000, 17'h00000, 2, 5, 6, 2, 1);
        vecs[11] = mk(0, 16'h0180, 1, 0, 1, 17'h00180, 17'h00000, 3, 5, 7, 3, 1);
        vecs[12] = mk(0, 16'h0200, 1, 0, 2, 17'h10080, 17'h00200, 4, 5, 8, 4, 2);
        vecs[13] = mk(1, 16'h0065, 0, 0, 1, 17'h00060, 17'h00000, 3, 5, 9, 4, 2);
        vecs[14] = mk(0, 16'h007F, 0, 1, 0, 17'h00000, 17'h00000, 2, 6, 9, 4, 2);
        vecs[15] = mk(0, 16'h00E0, 0, 0, 1, 17'h000E0, 17'h00000, 3, 6, 10, 4, 2);
        vecs[16] = mk(0, 16'h0160, 0, 0, 2, 17'h10060, 17'h00160, 4, 6, 11, 5, 3);

        repeat (3) @(negedge clk);
        checkOutput("rst_ready", req_ready, 0);
        checkOutput("rst_mem_valid", mem_req_valid, 0);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_cnt_access", cnt_access, 0);
        checkOutput("rst_cnt_miss", cnt_miss, 0);
        reset = 1'b1;
        #1;
        checkOutput("ready_after_release", req_ready, 1);

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].rw, vecs[i].addr, vecs[i].pol, 0, got_hit, n_mem, m0, m1, lat, unstable);
            checkOutput($sformatf("v%0d_hit", i), got_hit, vecs[i].hit);
            checkOutput($sformatf("v%0d_nmem", i), n_mem, vecs[i].nmem);
            if (vecs[i].nmem >= 1) checkOutput($sformatf("v%0d_mem0", i), m0, vecs[i].m0);
            if (vecs[i].nmem >= 2) checkOutput($sformatf("v%0d_mem1", i), m1, vecs[i].m1);
            checkOutput($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            checkOutput($sformatf("v%0d_cnt_hit", i), cnt_hit, vecs[i].hits);
            checkOutput($sformatf("v%0d_cnt_miss", i), cnt_miss, vecs[i].misses);
            checkOutput($sformatf("v%0d_cnt_evict", i), cnt_evict, vecs[i].evicts);
            checkOutput($sformatf("v%0d_cnt_wb", i), cnt_wb, vecs[i].wbs);
            checkOutput($sformatf("v%0d_cnt_access", i), cnt_access, m_access);
            checkOutput($sformatf("v%0d_cnt_read", i), cnt_read, m_read);
            checkOutput($sformatf("v%0d_cnt_write", i), cnt_write, m_write);
        end

        // Memory holds off the fill for ten cycles; request must stay put.
        applyStimulus(0, 16'h0300, 0, 10, got_hit, n_mem, m0, m1, lat, unstable);
        checkOutput("hold_hit", got_hit, 0);
        checkOutput("hold_nmem", n_mem, 1);
        checkOutput("hold_mem0", m0, 17'h00300);
        checkOutput("hold_stable", unstable, 0);
        checkOutput("hold_lat", lat, 13);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) extra++;
        end
        checkOutput("hold_one_resp", extra, 0);

        // Reset while a fill is outstanding.
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 16'h0020; wpolicy = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("abort_fill_active", mem_req_valid, 1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_mem_valid", mem_req_valid, 0);
        checkOutput("abort_resp_valid", resp_valid, 0);
        checkOutput("abort_ready_in_rst", req_ready, 0);
        checkOutput("abort_cnt_access", cnt_access, 0);
        checkOutput("abort_cnt_hit", cnt_hit, 0);
        reset = 1'b1;
        m_access = 0; m_read = 0; m_write = 0;
        #1;
        checkOutput("abort_idle_ready", req_ready, 1);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid || mem_req_valid) extra++;
        end
        checkOutput("abort_quiet", extra, 0);

        applyStimulus(0, 16'h0300, 0, 0, got_hit, n_mem, m0, m1, lat, unstable);
        checkOutput("post_rst_hit", got_hit, 0);
        checkOutput("post_rst_mem0", m0, 17'h00300);

        // Write-through miss must not allocate.
        applyStimulus(1, 16'h0040, 1, 0, got_hit, n_mem, m0, m1, lat, unstable);
        checkOutput("wt_hit", got_hit, 0);
        checkOutput("wt_nmem", n_mem, 1);
        checkOutput("wt_mem0", m0, 17'h10040);
        applyStimulus(0, 16'h0040, 0, 0, got_hit, n_mem, m0, m1, lat, unstable);
        checkOutput("wt_reread_hit", got_hit, 0);
        checkOutput("wt_reread_mem0", m0, 17'h00040);
        checkOutput("wt_cnt_evict", cnt_evict, 0);
        checkOutput("wt_cnt_wb", cnt_wb, 0);
        checkOutput("wt_cnt_access", cnt_access, m_access);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cache_tag_ctrl.md
CACHE_TAG_CTRL -- requirements
Module: cache_tag_ctrl

Interface
REQ-001 SHALL have parameter SETS, default 256, sets per way; power of 2, 2..2**20.
REQ-002 SHALL have parameter ASSOC, default 4, ways per set; power of 2, 1..8.
REQ-003 SHALL have parameter LINESIZE, default 32, bytes per line; power of 2, 4..128.
REQ-004 SHALL have parameter ADDRESS_SIZE, default 32, request address width in bits.
REQ-005 SHALL have parameter CNT_WIDTH, default 32, statistics counter width.
REQ-006 SHALL raise $fatal at elaboration when any parameter is out of range.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-008 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-009 SHALL have port req_valid, input, 1, request present.
REQ-010 SHALL have port req_ready, output, 1, block can accept a request.
REQ-011 SHALL have port req_rw, input, 1, 0=read, 1=write.
REQ-012 SHALL have port req_addr, input, ADDRESS_SIZE, byte address, split as {tag, index, byte-select}.
REQ-013 SHALL have port wpolicy, input, 1, 0=write-back/write-allocate, 1=write-through/no-allocate; sampled at accept.
REQ-014 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port resp_hit, output, 1, hit status, qualified by resp_valid.
REQ-016 SHALL have ports mem_req_valid (output, 1), mem_req_we (output, 1) and mem_req_addr (output, ADDRESS_SIZE), the line-aligned memory request.
REQ-017 SHALL have port mem_ack, input, 1, memory completes the current request.
REQ-018 SHALL have ports cnt_access, cnt_read, cnt_write, cnt_hit, cnt_miss, cnt_evict and cnt_wb, each output, CNT_WIDTH, statistics counters.

Function
REQ-019 SHALL hold, per way and set, a tag, a valid bit, a dirty bit, and an age of log2(ASSOC) bits; an ASSOC=1 build has no age bits.
REQ-020 SHALL implement the FSM states IDLE, LOOKUP, WB, FILL, WT and RESP.
REQ-021 SHALL assert req_ready only in IDLE, and accept a request when req_valid and req_ready are both high; accept latches req_rw, req_addr and wpolicy.
REQ-022 SHALL move IDLE->LOOKUP on accept; LOOKUP compares all ways in one cycle, and a hit requires valid and an equal tag.
REQ-023 SHALL take these LOOKUP transitions:
- read hit, or write hit in policy 0 -> RESP
- write hit in policy 1 -> WT
- miss, victim valid and dirty, and allocating -> WB
- miss and allocating -> FILL
- write miss in policy 1 -> WT
REQ-024 SHALL choose as victim the lowest-index invalid way, otherwise the way whose age equals ASSOC-1.
REQ-025 SHALL, in WB, drive mem_req_we=1 with mem_req_addr={victim tag, index, 0}; on mem_ack, go to FILL.
REQ-026 SHALL, in FILL, drive mem_req_we=0 with mem_req_addr={req tag, index, 0}; on mem_ack, install the tag with valid=1 and dirty=req_rw&~wpolicy, then go to RESP.
REQ-027 SHALL, in WT, drive mem_req_we=1 with the request line address; on mem_ack, go to RESP; a WT hit leaves the dirty bit unchanged.
REQ-028 SHALL set the dirty bit on a policy-0 write hit, in LOOKUP.
REQ-029 SHALL assert mem_req_valid throughout WB, FILL and WT, with mem_req_we and mem_req_addr stable until mem_ack; mem_ack is allowed in the first cycle of the state, and mem_ack outside these states is ignored.
REQ-030 SHALL pulse resp_valid for exactly one cycle in RESP, then return to IDLE; hit latency is 2 cycles from accept to resp_valid.
REQ-031 SHALL, on every hit or allocation, set the accessed way's age to 0 and increment each same-set way whose age is below the accessed way's old age; ages stay a permutation of 0..ASSOC-1.
REQ-032 SHALL leave LRU ages and tag state unchanged on a policy-1 write miss.
REQ-033 SHALL update statistics counters as follows:
- cnt_access increments on every accept; cnt_read or cnt_write increments by req_rw
- cnt_hit or cnt_miss increments in LOOKUP
- cnt_evict increments when the victim is valid and allocation occurs
- cnt_wb increments on WB completion
REQ-034 SHALL saturate every counter at all-ones with no wrap.
REQ-035 SHALL, for dirty lines left over after a policy change, still write them back on eviction.

Reset
REQ-036 SHALL, while reset=0 at a clk edge, go to IDLE and clear all valid and dirty bits, set age[w]=w, and zero all counters.
REQ-037 SHALL drive all outputs 0 during reset, except req_ready, which is 0 during reset and 1 in the first cycle after release.
REQ-038 SHALL treat a reset mid-transaction (WB, FILL or WT) as aborting it: mem_req_valid=0 from the next cycle, with no resp_valid.
REQ-039 SHALL allow the reset-clear of all sets to take 1 cycle or SETS cycles; when it takes SETS cycles, req_ready=0 until clearing completes.

Verification
All scenarios use the config SETS=4, ASSOC=2, LINESIZE=32, ADDRESS_SIZE=16, policy 0 unless stated.
REQ-040 Cold read 0x0000, then ack -> FILL with mem_req_addr=0x0000 and we=0, resp_hit=0; reread 0x0000 -> resp_hit=1 two cycles after accept; cnt_hit=1, cnt_miss=1.
REQ-041 LRU sequence:
- write 0x0000, read 0x0080, read 0x0000, read 0x0100 -> 0x0080 evicted clean; cnt_evict=1, cnt_wb=0, single mem read.
- then read 0x0080 -> mem write 0x0000 followed by mem read 0x0080; cnt_wb=1, cnt_evict=2.
REQ-042 Policy 1 write 0x0040 -> a single mem write to 0x0040 and no fill; then read 0x0040 -> miss; cnt_evict=0.
REQ-043 Hold mem_ack=0 for 10 cycles in FILL -> mem_req_valid, we and addr stable, req_ready=0 throughout, and exactly one resp_valid after ack.
REQ-044 Reset low during FILL -> next cycle IDLE, mem_req_valid=0 and counters 0, and a read of the previously cached line misses.
